// File: rtl/clock_pkg.sv
// Shared definitions for the clock-digit counter family: field moduli, the BCD
// digit type and a constant-foldable ceil(log2) used for parameter checks.
package clock_pkg;

    // Standard clock field moduli.
    localparam int unsigned SEC_MOD    = 60;
    localparam int unsigned MIN_MOD    = 60;
    localparam int unsigned HOUR24_MOD = 24;
    localparam int unsigned HOUR12_MOD = 12;

    // Largest value the two-digit BCD converter represents correctly.
    localparam int unsigned BCD_MAX = 99;

    // One decimal digit for the display decoder.
    typedef logic [3:0] bcd_digit_t;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        longint unsigned span;
        result = 0;
        span   = 1;
        while (span < longint'(value)) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_counter_ud_if.sv
// Control/status bundle of one modulo-N clock field counter. The master side
// (sequencer or neighbouring field) drives the controls; the counter is the slave.
interface mod_counter_ud_if
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH = 7
);

    logic             en;
    logic             load;
    logic             up;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] count;
    logic             rco;
    logic             borrow;
    logic             tc;
    logic             load_err;
    bcd_digit_t       tens;
    bcd_digit_t       ones;

    modport master (
        output en, load, up, data,
        input  count, rco, borrow, tc, load_err, tens, ones
    );

    modport slave (
        input  en, load, up, data,
        output count, rco, borrow, tc, load_err, tens, ones
    );

endinterface

// File: rtl/bin2bcd_2dig.sv
// Combinational binary (0..99) to two BCD digits. Shared by the counter's
// display outputs, the display mux and the alarm compare.
module bin2bcd_2dig
    import clock_pkg::*;
(
    input  logic [6:0] bin_i,
    output bcd_digit_t tens_o,
    output bcd_digit_t ones_o
);

    // Constant divisor: synthesises to a small compare/subtract network.
    assign tens_o = 4'(bin_i / 7'd10);
    assign ones_o = 4'(bin_i % 7'd10);

endmodule

// File: rtl/mod_counter_ud.sv
// Modulo-N up/down counter for one clock field (seconds, minutes, hours).
// Registered count and carry/borrow/load-error pulses, combinational terminal
// count for ripple-free cascading, and BCD digits for the display.
module mod_counter_ud
    import clock_pkg::*;
#(
    parameter int unsigned MODULUS = 24,
    parameter int unsigned WIDTH   = 7
) (
    input logic            clk,
    input logic            rst,
    mod_counter_ud_if.slave bus
);

    // Elaboration-time parameter checks.
    if (MODULUS < 2 || MODULUS > BCD_MAX + 1) begin : g_bad_modulus
        $error("mod_counter_ud: MODULUS %0d outside 2..100", MODULUS);
    end
    if (clog2(MODULUS) > WIDTH) begin : g_bad_width
        $error("mod_counter_ud: WIDTH %0d too small for MODULUS %0d", WIDTH, MODULUS);
    end

    // All compares and steps run one bit wider so +1 / -1 never alias.
    localparam int unsigned   WExt   = WIDTH + 1;
    localparam logic [WIDTH:0] ModExt = WExt'(MODULUS);
    localparam logic [WIDTH:0] MaxExt = WExt'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             rco_q, rco_d;
    logic             borrow_q, borrow_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   data_ext;
    logic [6:0]       bcd_bin;

    assign count_ext = {1'b0, count_q};
    assign data_ext  = {1'b0, bus.data};

    // Next-state: load beats count enable; pulses default low every cycle.
    always_comb begin
        count_d    = count_q;
        rco_d      = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;

        if (bus.load) begin
            if (data_ext < ModExt) begin
                count_d = bus.data;
            end else begin
                count_d    = '0;
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                // >= also catches an out-of-range count and wraps it to 0.
                if (count_ext >= MaxExt) begin
                    count_d = '0;
                    rco_d   = 1'b1;
                end else begin
                    count_d = WIDTH'(count_ext + 1'b1);
                end
            end else begin
                // An out-of-range count wraps to the top like a zero would.
                if (count_ext == '0 || count_ext > MaxExt) begin
                    count_d  = WIDTH'(MaxExt);
                    borrow_d = 1'b1;
                end else begin
                    count_d = WIDTH'(count_ext - 1'b1);
                end
            end
        end
    end

    // State register; reset abandons any pending load or step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            rco_q      <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rco_q      <= rco_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.rco      = rco_q;
    assign bus.borrow   = borrow_q;
    assign bus.load_err = load_err_q;

    // Terminal count ignores en so the next field can gate with this en & tc.
    assign bus.tc = bus.up ? (count_ext == MaxExt) : (count_ext == '0);

    // Count never exceeds 99 in a legal configuration, so 7 bits suffice.
    assign bcd_bin = 7'(count_q);

    bin2bcd_2dig u_bcd (
        .bin_i  (bcd_bin),
        .tens_o (bus.tens),
        .ones_o (bus.ones)
    );

endmodule

// File: tb/tb_mod_counter_ud.sv
// Bench for mod_counter_ud: directed scenarios plus randomized traffic against a
// modular-arithmetic reference model, and a seconds->hours cascade.
module tb_mod_counter_ud;
    import clock_pkg::*;

    localparam int unsigned W   = 7;
    localparam int          MOD = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mod_counter_ud_if #(.WIDTH(W)) d_if ();
    mod_counter_ud_if #(.WIDTH(W)) s_if ();
    mod_counter_ud_if #(.WIDTH(W)) h_if ();

    mod_counter_ud #(.MODULUS(MOD), .WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (d_if.slave)
    );

    mod_counter_ud #(.MODULUS(SEC_MOD), .WIDTH(W)) u_sec (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    mod_counter_ud #(.MODULUS(HOUR24_MOD), .WIDTH(W)) u_hr (
        .clk (clk),
        .rst (rst),
        .bus (h_if.slave)
    );

    // Cascade: hours steps when seconds is enabled and at its terminal count.
    assign h_if.en   = s_if.en & s_if.tc;
    assign h_if.load = 1'b0;
    assign h_if.up   = 1'b1;
    assign h_if.data = '0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state for u_dut.
    int m_cnt = 0;
    bit m_rco = 1'b0;
    bit m_bor = 1'b0;
    bit m_err = 1'b0;
    bit cur_up = 1'b1;

    function automatic void model_reset();
        m_cnt = 0;
        m_rco = 1'b0;
        m_bor = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic void model_edge(input bit en, input bit ld, input bit up, input int data);
        m_rco = 1'b0;
        m_bor = 1'b0;
        m_err = 1'b0;
        if (ld) begin
            if (data < MOD) begin
                m_cnt = data;
            end else begin
                m_cnt = 0;
                m_err = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                m_cnt = (m_cnt + 1) % MOD;
                m_rco = (m_cnt == 0);
            end else begin
                m_cnt = (m_cnt + MOD - 1) % MOD;
                m_bor = (m_cnt == MOD - 1);
            end
        end
    endfunction

    function automatic bit model_tc();
        return (cur_up && m_cnt == MOD - 1) || (!cur_up && m_cnt == 0);
    endfunction

    // Apply inputs, take one edge, update the model, settle just past the edge.
    task automatic step(input bit en, input bit ld, input bit up, input int data);
        d_if.en   = en;
        d_if.load = ld;
        d_if.up   = up;
        d_if.data = W'(data);
        cur_up    = up;
        @(posedge clk);
        if (!rst) model_edge(en, ld, up, data);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (d_if.count !== '0 || d_if.rco !== 1'b0 || d_if.borrow !== 1'b0
            || d_if.load_err !== 1'b0)
            begin n_err++; $display("FAIL reset_state: count=%0d rco=%b borrow=%b lerr=%b required 0/0/0/0",
                d_if.count, d_if.rco, d_if.borrow, d_if.load_err); end
        // Edges with en=1 while reset is held must be ignored.
        d_if.en = 1'b1;
        d_if.up = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (d_if.count !== '0)
            begin n_err++; $display("FAIL reset_hold: count=%0d required 0", d_if.count); end
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (d_if.rco !== 1'b0 || d_if.count !== '0)
            begin n_err++; $display("FAIL reset_release: count=%0d rco=%b required 0/0",
                d_if.count, d_if.rco); end
    endtask

    task automatic test_count_up();
        for (int i = 1; i <= MOD; i++) begin
            step(1'b1, 1'b0, 1'b1, 0);
            n_cmp++;
            if (d_if.count !== W'(m_cnt))
                begin n_err++; $display("FAIL up_count[%0d]: got %0d required %0d", i, d_if.count, m_cnt); end
            n_cmp++;
            if (d_if.rco !== m_rco || d_if.borrow !== 1'b0)
                begin n_err++; $display("FAIL up_rco[%0d]: rco=%b borrow=%b required %b/0",
                    i, d_if.rco, d_if.borrow, m_rco); end
            if (i == 23) begin
                n_cmp++;
                if (d_if.tens !== 4'd2 || d_if.ones !== 4'd3 || d_if.tc !== 1'b1)
                    begin n_err++; $display("FAIL up_bcd23: tens=%0d ones=%0d tc=%b required 2/3/1",
                        d_if.tens, d_if.ones, d_if.tc); end
            end
        end
    endtask

    task automatic test_count_down();
        step(1'b0, 1'b1, 1'b0, 0);
        n_cmp++;
        if (d_if.count !== '0 || d_if.tc !== 1'b1)
            begin n_err++; $display("FAIL down_tc0: count=%0d tc=%b required 0/1", d_if.count, d_if.tc); end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            n_cmp++;
            if (d_if.count !== W'(MOD - i) || d_if.borrow !== (i == 1) || d_if.rco !== 1'b0)
                begin n_err++; $display("FAIL down_step[%0d]: count=%0d borrow=%b rco=%b required %0d/%b/0",
                    i, d_if.count, d_if.borrow, d_if.rco, MOD - i, (i == 1)); end
        end
    endtask

    task automatic test_load_err();
        step(1'b1, 1'b1, 1'b1, 30);
        n_cmp++;
        if (d_if.count !== '0 || d_if.load_err !== 1'b1 || d_if.rco !== 1'b0)
            begin n_err++; $display("FAIL load_bad: count=%0d lerr=%b rco=%b required 0/1/0",
                d_if.count, d_if.load_err, d_if.rco); end
        step(1'b0, 1'b1, 1'b1, 17);
        n_cmp++;
        if (d_if.count !== W'(17) || d_if.load_err !== 1'b0)
            begin n_err++; $display("FAIL load_good: count=%0d lerr=%b required 17/0",
                d_if.count, d_if.load_err); end
        // Boundary: MODULUS-1 is legal, MODULUS is not.
        step(1'b0, 1'b1, 1'b1, MOD);
        n_cmp++;
        if (d_if.count !== '0 || d_if.load_err !== 1'b1)
            begin n_err++; $display("FAIL load_mod: count=%0d lerr=%b required 0/1",
                d_if.count, d_if.load_err); end
    endtask

    task automatic test_priority_hold();
        step(1'b0, 1'b1, 1'b1, MOD - 1);
        n_cmp++;
        if (d_if.count !== W'(MOD - 1) || d_if.load_err !== 1'b0)
            begin n_err++; $display("FAIL load_max: count=%0d lerr=%b required %0d/0",
                d_if.count, d_if.load_err, MOD - 1); end
        step(1'b1, 1'b1, 1'b1, 5);
        n_cmp++;
        if (d_if.count !== W'(5) || d_if.rco !== 1'b0)
            begin n_err++; $display("FAIL prio_load: count=%0d rco=%b required 5/0", d_if.count, d_if.rco); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0], 0);
            n_cmp++;
            if (d_if.count !== W'(5) || d_if.rco !== 1'b0 || d_if.borrow !== 1'b0
                || d_if.load_err !== 1'b0)
                begin n_err++; $display("FAIL hold[%0d]: count=%0d rco=%b borrow=%b lerr=%b required 5/0/0/0",
                    i, d_if.count, d_if.rco, d_if.borrow, d_if.load_err); end
        end
    endtask

    task automatic test_random();
        bit en, ld, up;
        int data;
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom % 4) != 0;
            ld   = ($urandom % 8) == 0;
            up   = $urandom % 2;
            data = $urandom % 40;
            step(en, ld, up, data);
            n_cmp++;
            if (d_if.count !== W'(m_cnt) || d_if.rco !== m_rco || d_if.borrow !== m_bor
                || d_if.load_err !== m_err || d_if.tc !== model_tc()
                || d_if.tens !== 4'(m_cnt / 10) || d_if.ones !== 4'(m_cnt % 10))
                begin n_err++; $display("FAIL random[%0d]: count=%0d rco=%b bor=%b lerr=%b tc=%b bcd=%0d%0d required %0d/%b/%b/%b/%b",
                    i, d_if.count, d_if.rco, d_if.borrow, d_if.load_err, d_if.tc, d_if.tens,
                    d_if.ones, m_cnt, m_rco, m_bor, m_err, model_tc()); end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b1, 12);
        n_cmp++;
        if (d_if.count !== W'(12))
            begin n_err++; $display("FAIL async_pre: count=%0d required 12", d_if.count); end
        d_if.load = 1'b0;
        d_if.en   = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (d_if.count !== '0 || d_if.rco !== 1'b0 || d_if.borrow !== 1'b0
            || d_if.load_err !== 1'b0)
            begin n_err++; $display("FAIL async_clear: count=%0d rco=%b borrow=%b lerr=%b required 0/0/0/0",
                d_if.count, d_if.rco, d_if.borrow, d_if.load_err); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (d_if.count !== '0)
            begin n_err++; $display("FAIL async_hold: count=%0d required 0", d_if.count); end
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 1'b1, 0);
        n_cmp++;
        if (d_if.count !== W'(1) || d_if.rco !== 1'b0)
            begin n_err++; $display("FAIL async_release: count=%0d rco=%b required 1/0",
                d_if.count, d_if.rco); end
    endtask

    task automatic test_cascade();
        int total;
        total = SEC_MOD * HOUR24_MOD;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        s_if.en = 1'b1;
        s_if.up = 1'b1;
        for (int k = 1; k <= total; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (s_if.count !== W'(k % SEC_MOD) || h_if.count !== W'((k / SEC_MOD) % HOUR24_MOD))
                begin n_err++; $display("FAIL cascade_count[%0d]: %0d:%0d required %0d:%0d", k,
                    h_if.count, s_if.count, (k / SEC_MOD) % HOUR24_MOD, k % SEC_MOD); end
            n_cmp++;
            if (s_if.rco !== (k % SEC_MOD == 0) || h_if.rco !== (k % total == 0))
                begin n_err++; $display("FAIL cascade_rco[%0d]: sec_rco=%b hr_rco=%b required %b/%b", k,
                    s_if.rco, h_if.rco, (k % SEC_MOD == 0), (k % total == 0)); end
        end
        s_if.en = 1'b0;
    endtask

    initial begin
        d_if.en   = 1'b0;
        d_if.load = 1'b0;
        d_if.up   = 1'b1;
        d_if.data = '0;
        s_if.en   = 1'b0;
        s_if.load = 1'b0;
        s_if.up   = 1'b1;
        s_if.data = '0;
        #1;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_err();
        test_priority_hold();
        test_random();
        test_async_reset();
        test_cascade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
